// File: rtl/alu_pkg.sv
// Opcode encodings, FSM state type and opcode-class helpers shared by the
// sequential ALU/MDU and its combinational base ALU.
package alu_pkg;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SLL   = 5'b00001;
    localparam logic [4:0] ALU_SLT   = 5'b00010;
    localparam logic [4:0] ALU_PASSB = 5'b00011;
    localparam logic [4:0] ALU_XOR   = 5'b00100;
    localparam logic [4:0] ALU_SRL   = 5'b00101;
    localparam logic [4:0] ALU_OR    = 5'b00110;
    localparam logic [4:0] ALU_AND   = 5'b00111;
    localparam logic [4:0] ALU_SUB   = 5'b01000;
    localparam logic [4:0] ALU_SLTU  = 5'b01010;
    localparam logic [4:0] ALU_SRA   = 5'b01101;

    localparam logic [4:0] MDU_MUL    = 5'b10000;
    localparam logic [4:0] MDU_MULH   = 5'b10001;
    localparam logic [4:0] MDU_MULHSU = 5'b10010;
    localparam logic [4:0] MDU_MULHU  = 5'b10011;
    localparam logic [4:0] MDU_DIV    = 5'b10100;
    localparam logic [4:0] MDU_DIVU   = 5'b10101;
    localparam logic [4:0] MDU_REM    = 5'b10110;
    localparam logic [4:0] MDU_REMU   = 5'b10111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    function automatic logic is_mdu(input logic [4:0] op);
        return op[4];
    endfunction

    // Operand A is signed for MUL/MULH/MULHSU/DIV/REM.
    function automatic logic a_signed(input logic [2:0] f);
        return f[2] ? !f[0] : (f[1:0] != 2'b11);
    endfunction

    // Operand B is signed for MUL/MULH/DIV/REM.
    function automatic logic b_signed(input logic [2:0] f);
        return f[2] ? !f[0] : !f[1];
    endfunction

endpackage

// File: rtl/alu_base_comb.sv
// Purely combinational base ALU (RV32I-style ops, XLEN wide).
module alu_base_comb
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] da_i,
    input  logic [XLEN-1:0] db_i,
    input  logic [4:0]      aluctr_i,
    output logic [XLEN-1:0] result_o
);

    localparam int SW = $clog2(XLEN);

    logic [SW-1:0] shamt;
    assign shamt = db_i[SW-1:0];

    always_comb begin
        result_o = '0;
        case (aluctr_i)
            ALU_ADD:   result_o = da_i + db_i;
            ALU_SUB:   result_o = da_i - db_i;
            ALU_SLL:   result_o = da_i << shamt;
            ALU_SLT:   result_o = XLEN'($signed(da_i) < $signed(db_i));
            ALU_SLTU:  result_o = XLEN'(da_i < db_i);
            ALU_PASSB: result_o = db_i;
            ALU_XOR:   result_o = da_i ^ db_i;
            ALU_SRL:   result_o = da_i >> shamt;
            ALU_SRA:   result_o = $signed(da_i) >>> shamt;
            ALU_OR:    result_o = da_i | db_i;
            ALU_AND:   result_o = da_i & db_i;
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_mdu_seq.sv
// EX-stage ALU with registered output and an iterative radix-2 M-extension unit.
// States: IDLE accept/base op | CALC one shift-add or restoring-subtract step | FIX sign fix + register.
module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit EN_MDU = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] da,
    input  logic [XLEN-1:0] db,
    input  logic [4:0]      aluctr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   da_q, da_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic              nega_q, nega_d;
    logic              dbz_q, dbz_d;
    logic              ovf_q, ovf_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              out_valid_q, out_valid_d;

    logic [XLEN-1:0]   base_res;
    logic              accept, mdu_op;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;

    alu_base_comb #(.XLEN(XLEN)) u_base (
        .da_i     (da),
        .db_i     (db),
        .aluctr_i (aluctr),
        .result_o (base_res)
    );

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mdu_op    = EN_MDU && is_mdu(aluctr);
    assign a_neg     = a_signed(aluctr[2:0]) && da[XLEN-1];
    assign b_neg     = b_signed(aluctr[2:0]) && db[XLEN-1];
    assign mag_a     = a_neg ? -da : da;
    assign mag_b     = b_neg ? -db : db;

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign busy      = EN_MDU && (state_q != IDLE);

    // Multiply: acc = {partial product, remaining multiplier bits}.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    // Divide: acc = {partial remainder, dividend bits becoming quotient bits}.
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = !div_diff[XLEN];
        div_next  = {div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0],
                     acc_q[XLEN-2:0], div_ge};
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = neg_q  ? -acc_q : acc_q;
        quot_fix = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = nega_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        fix_res  = '0;
        case ({2'b10, op_q})
            MDU_MUL:    fix_res = prod_fix[XLEN-1:0];
            MDU_MULH,
            MDU_MULHSU,
            MDU_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV,
            MDU_DIVU:   fix_res = dbz_q ? '1 : (ovf_q ? da_q : quot_fix);
            MDU_REM,
            MDU_REMU:   fix_res = dbz_q ? da_q : (ovf_q ? '0 : rem_fix);
            default:    fix_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        da_d        = da_q;
        op_d        = op_q;
        neg_d       = neg_q;
        nega_d      = nega_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (mdu_op) begin
                        state_d = CALC;
                        count_d = '0;
                        acc_d   = {{XLEN{1'b0}}, mag_a};
                        opnd_d  = mag_b;
                        da_d    = da;
                        op_d    = aluctr[2:0];
                        neg_d   = a_neg ^ b_neg;
                        nega_d  = a_neg;
                        dbz_d   = (db == '0);
                        ovf_d   = aluctr[2] && !aluctr[0]
                                  && (da == {1'b1, {(XLEN-1){1'b0}}}) && (db == '1);
                    end else begin
                        result_d    = base_res;
                        out_valid_d = 1'b1;
                    end
                end
            end
            CALC: begin
                acc_d   = op_q[2] ? div_next : mul_next;
                count_d = count_q + CW'(1);
                if (count_q == CW'(XLEN-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d    = fix_res;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            da_q        <= '0;
            op_q        <= '0;
            neg_q       <= 1'b0;
            nega_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            da_q        <= da_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            nega_q      <= nega_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq: 32-bit instance for ops/handshake/reset, 64-bit for wide MUL.
module tb_alu_mdu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [31:0] da, db, result;
    logic [4:0]  aluctr;

    logic        v_in_valid, v_in_ready, v_out_valid, v_out_ready, v_zero, v_busy;
    logic [63:0] v_da, v_db, v_result;
    logic [4:0]  v_aluctr;

    alu_mdu_seq #(.XLEN(32), .EN_MDU(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .da(da), .db(db), .aluctr(aluctr), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    alu_mdu_seq #(.XLEN(64), .EN_MDU(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v_in_valid), .in_ready(v_in_ready),
        .da(v_da), .db(v_db), .aluctr(v_aluctr), .out_valid(v_out_valid),
        .out_ready(v_out_ready), .result(v_result), .zero(v_zero), .busy(v_busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        up;
        logic [31:0]        r;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
        r   = '0;
        if (op[4]) begin
            case (op[2:0])
                3'd0: begin sp = sa * sb; r = sp[31:0]; end
                3'd1: begin sp = sa * sb; r = sp[63:32]; end
                3'd2: begin sp = sa * $signed({32'b0, b}); r = sp[63:32]; end
                3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
                3'd4: if (b == 0) r = '1; else if (ovf) r = a; else begin sp = sa / sb; r = sp[31:0]; end
                3'd5: r = (b == 0) ? 32'hffff_ffff : a / b;
                3'd6: if (b == 0) r = a; else if (ovf) r = '0; else begin sp = sa % sb; r = sp[31:0]; end
                default: r = (b == 0) ? a : a % b;
            endcase
        end else begin
            case (op[3:0])
                4'd0:  r = a + b;
                4'd8:  r = a - b;
                4'd1:  r = a << b[4:0];
                4'd2:  r = {31'b0, $signed(a) < $signed(b)};
                4'd10: r = {31'b0, a < b};
                4'd3:  r = b;
                4'd4:  r = a ^ b;
                4'd5:  r = a >> b[4:0];
                4'd13: r = $signed(a) >>> b[4:0];
                4'd6:  r = a | b;
                4'd7:  r = a & b;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // Scoreboard: compares every consumed output against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_output got=%h", result);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checks++;
                if (result !== e.res) begin
                    failures++;
                    $display("FAIL sb_result got=%h exp=%h", result, e.res);
                end
                checks++;
                if (zero !== (e.res == 32'h0)) begin
                    failures++;
                    $display("FAIL sb_zero got=%b exp=%b", zero, (e.res == 32'h0));
                end
                if (e.lat > 0) begin
                    checks++;
                    if ((cyc - e.acc + 1) != e.lat) begin
                        failures++;
                        $display("FAIL sb_latency got=%0d exp=%0d", cyc - e.acc + 1, e.lat);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        int   n;
        exp_t e;
        aluctr   = op;
        da       = a;
        db       = b;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL accept_timeout got=in_ready_low exp=in_ready_high");
        end else begin
            e.res = exp;
            e.acc = cyc + 1;
            e.lat = lat;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        da       = $urandom;
        db       = $urandom;
        aluctr   = 5'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got=%0d_pending exp=0", sbq.size());
        end
        sbq.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        da          = '0;
        db          = '0;
        aluctr      = '0;
        v_in_valid  = 1'b0;
        v_out_ready = 1'b1;
        v_da        = '0;
        v_db        = '0;
        v_aluctr    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (result !== 32'h0)   begin failures++; $display("FAIL rst_result got=%h exp=0", result); end
        checks++; if (zero !== 1'b1)      begin failures++; $display("FAIL rst_zero got=%b exp=1", zero); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        checks++; if (v_out_valid !== 1'b0) begin failures++; $display("FAIL rst64_out_valid got=%b exp=0", v_out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_base();
        out_ready = 1'b1;
        issue(ALU_ADD,   32'h1f,        32'h2e, 32'h4d,        1);
        issue(ALU_SLL,   32'hcdef,      32'd4,  32'h000c_def0, 1);
        issue(ALU_SRA,   32'hfe00_0000, 32'd4,  32'hffe0_0000, 1);
        issue(ALU_SUB,   32'hffff_ffff, 32'hffff_ffff, 32'h0,  1);
        issue(ALU_SRL,   32'hfe00_0000, 32'd36, 32'h0fe0_0000, 1);
        issue(ALU_SLT,   32'hffff_ffff, 32'd1,  32'd1,         1);
        issue(ALU_SLTU,  32'hffff_ffff, 32'd1,  32'd0,         1);
        issue(ALU_PASSB, 32'h1234,      32'h5678, 32'h5678,    1);
        issue(5'b01001,  32'h1234,      32'h5678, 32'h0,       1);
        wait_drain();
    endtask

    task automatic test_mul();
        out_ready = 1'b1;
        issue(MDU_MUL, 32'hffff_ffff, 32'd1, 32'hffff_ffff, 34);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mul_busy got=%b exp=1", busy); end
        issue(MDU_MULH,   32'hffff_ffff, 32'd1,     32'hffff_ffff, 34);
        issue(MDU_MULHU,  32'hffff_ffff, 32'd1,     32'h0,         34);
        issue(MDU_MULHSU, 32'hffff_ffff, 32'd2,     32'hffff_ffff, 34);
        issue(MDU_MUL,    32'd12345,     32'd678,   32'd8369910,   34);
        wait_drain();
    endtask

    task automatic test_div();
        out_ready = 1'b1;
        issue(MDU_DIVU, 32'd7,         32'd0,         32'hffff_ffff, 34);
        issue(MDU_REM,  32'd7,         32'd0,         32'd7,         34);
        issue(MDU_DIV,  32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 34);
        issue(MDU_REM,  32'h8000_0000, 32'hffff_ffff, 32'h0,         34);
        issue(MDU_DIV,  32'hffff_fff9, 32'd2,         32'hffff_fffd, 34);
        issue(MDU_REM,  32'hffff_fff9, 32'd2,         32'hffff_ffff, 34);
        issue(MDU_DIVU, 32'd100,       32'd7,         32'd14,        34);
        issue(MDU_REMU, 32'd100,       32'd7,         32'd2,         34);
        issue(MDU_DIV,  32'd7,         32'hffff_fffe, 32'hffff_fffd, 34);
        wait_drain();
    endtask

    task automatic test_backpressure();
        exp_t e;
        out_ready = 1'b0;
        issue(ALU_ADD, 32'd5, 32'd6, 32'd11, 0);
        aluctr   = ALU_XOR;
        da       = 32'ha5a5_a5a5;
        db       = 32'h0f0f_0f0f;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%b exp=1", out_valid); end
            checks++; if (result !== 32'd11) begin failures++; $display("FAIL bp_hold_result got=%h exp=%h", result, 32'd11); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        e.res = 32'haaaa_aaaa;
        e.acc = cyc + 1;
        e.lat = 1;
        sbq.push_back(e);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_same_cycle_accept got=%b exp=1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_new_valid got=%b exp=1", out_valid); end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  op;
        logic [31:0] a, b;
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            op = 5'($urandom_range(0, 31));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
            issue(op, a, b, model(op, a, b), op[4] ? 34 : 1);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid_div();
        int n;
        int stray;
        out_ready = 1'b1;
        aluctr    = MDU_DIV;
        da        = 32'd100;
        db        = 32'd3;
        in_valid  = 1'b1;
        n         = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rdiv_busy_before got=%b exp=1", busy); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rdiv_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL rdiv_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL rdiv_in_ready got=%b exp=1", in_ready); end
        checks++; if (result !== 32'h0)   begin failures++; $display("FAIL rdiv_result got=%h exp=0", result); end
        checks++; if (zero !== 1'b1)      begin failures++; $display("FAIL rdiv_zero got=%b exp=1", zero); end
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        checks++; if (stray != 0) begin failures++; $display("FAIL rdiv_stray_output got=%0d exp=0", stray); end
        @(posedge clk);
        #1;
    endtask

    task automatic run64(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp);
        int n;
        int lat;
        v_aluctr   = op;
        v_da       = a;
        v_db       = b;
        v_in_valid = 1'b1;
        n          = 0;
        @(negedge clk);
        while (!v_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        v_in_valid = 1'b0;
        v_da       = '1;
        lat        = 1;
        @(negedge clk);
        while (!v_out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (v_result !== exp) begin failures++; $display("FAIL x64_result got=%h exp=%h", v_result, exp); end
        checks++; if (lat != 66) begin failures++; $display("FAIL x64_latency got=%0d exp=66", lat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_xlen64();
        v_out_ready = 1'b1;
        run64(MDU_MUL,   64'h1_0000_0000, 64'h1_0000_0000, 64'h0);
        run64(MDU_MULHU, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1);
        run64(MDU_MULH,  64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_ffff, 64'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_base();
        test_mul();
        test_div();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_div();
        test_xlen64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
